cosim_retire_serializer: RTL

COSIM_RETIRE_SERIALIZER -- requirements
Module: cosim_retire_serializer

---
 rtl/cosim_retire_serializer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cosim_retire_serializer.sv
// Serializes up to NUM_PORTS retired instructions per cycle into a single-record FWFT stream
// for a cosimulation step driver, with drain-on-halt and sticky error/status reporting.
module cosim_retire_serializer #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned XLEN      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      ret_valid_i,
  input  logic [NUM_PORTS*XLEN-1:0] ret_pc_i,
  input  logic [NUM_PORTS*XLEN-1:0] ret_insn_i,
  input  logic [NUM_PORTS-1:0]      ret_rd_we_i,
  input  logic [NUM_PORTS*5-1:0]    ret_rd_addr_i,
  input  logic [NUM_PORTS*XLEN-1:0] ret_rd_data_i,
  input  logic                      halt_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [XLEN-1:0]           out_pc_o,
  output logic [XLEN-1:0]           out_insn_o,
  output logic [XLEN-1:0]           out_rd_data_o,
  output logic                      out_rd_we_o,
  output logic [4:0]                out_rd_addr_o,
  output logic [31:0]               out_seq_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(DEPTH):0]    high_water_o,
  output logic                      overflow_o,
  output logic                      protocol_err_o,
  output logic                      drained_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] hw_q, hw_d;
  logic [31:0]     seq_q, seq_d;
  logic            ovf_q, ovf_d;
  logic            perr_q, perr_d;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] insn_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic            we_mem_q   [DEPTH];
  logic [4:0]      addr_mem_q [DEPTH];

  logic [CntW-1:0]      n;
  logic [CntW-1:0]      free;
  logic [NUM_PORTS-1:0] valid_inc;
  logic                 contig;
  logic                 any_valid;
  logic                 pop;
  logic                 push;

  always_comb begin
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n = n + CntW'(ret_valid_i[i]);
    end
    // A contiguous run from slot 0 is 2^k-1, so adding one clears every set bit.
    valid_inc = ret_valid_i + NUM_PORTS'(1);
    contig    = ((ret_valid_i & valid_inc) == '0);
    any_valid = |ret_valid_i;
    pop       = out_valid_o & out_ready_i;
    free      = CntW'(DEPTH) - count_q + CntW'(pop);

    push    = 1'b0;
    state_d = state_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;

    case (state_q)
      StRun: begin
        if (any_valid) begin
          if (!contig) begin
            perr_d = 1'b1;
          end else if (n > free) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        if (halt_i) state_d = StDrain;
      end
      StDrain: begin
        if (any_valid) perr_d = 1'b1;
        if (count_q == '0) state_d = StDone;
      end
      StDone: begin
        if (any_valid) perr_d = 1'b1;
      end
      default: state_d = StRun;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrW'(n) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + (push ? n : '0) - CntW'(pop);
    seq_d    = seq_q + 32'(pop);
    hw_d     = (count_d > hw_q) ? count_d : hw_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StRun;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hw_q     <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hw_q     <= hw_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!reset && push && ret_valid_i[i]) begin
        pc_mem_q[wr_ptr_q + PtrW'(i)]   <= ret_pc_i[i*XLEN +: XLEN];
        insn_mem_q[wr_ptr_q + PtrW'(i)] <= ret_insn_i[i*XLEN +: XLEN];
        data_mem_q[wr_ptr_q + PtrW'(i)] <= ret_rd_data_i[i*XLEN +: XLEN];
        we_mem_q[wr_ptr_q + PtrW'(i)]   <= ret_rd_we_i[i];
        addr_mem_q[wr_ptr_q + PtrW'(i)] <= ret_rd_addr_i[i*5 +: 5];
      end
    end
  end

  assign out_valid_o    = (count_q != '0);
  assign out_pc_o       = pc_mem_q[rd_ptr_q];
  assign out_insn_o     = insn_mem_q[rd_ptr_q];
  assign out_rd_data_o  = data_mem_q[rd_ptr_q];
  assign out_rd_we_o    = we_mem_q[rd_ptr_q];
  assign out_rd_addr_o  = addr_mem_q[rd_ptr_q];
  assign out_seq_o      = seq_q;
  assign count_o        = count_q;
  assign high_water_o   = hw_q;
  assign overflow_o     = ovf_q;
  assign protocol_err_o = perr_q;
  assign drained_o      = (state_q == StDone);

endmodule
